// File: rtl/chan_mux_rr.sv
// chan_mux_rr
//   N-channel, WIDTH-bit registered multiplexer with valid/ready handshakes.
//   Channel arbitration is either a fixed select (mode=0, via sel) or
//   round-robin (mode=1) starting after the most recently granted channel.
//   A one-entry output register decouples the consumer and sustains full
//   throughput: a new beat loads in the same cycle the held beat drains.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   in_data      NUM_CH*WIDTH, channel i at [i*WIDTH +: WIDTH]
//   in_valid     per-channel valid
//   in_ready     per-channel ready (combinational, at most one bit high)
//   mode         0 = fixed select, 1 = round-robin
//   sel          channel select in fixed mode (ignored in round-robin)
//   out_data     registered data
//   out_valid    registered valid
//   out_ch       source channel of out_data
//   out_ready    consumer ready
//
// Optional feature (macro CHAN_MUX_RR_CNT_EN)
//   clr_cnt      synchronous clear of the transfer counter (wins over increment)
//   xfer_cnt     16-bit saturating count of out-side transfers

// Per-channel slice: handshake gating and AND-masked data for the OR-tree mux.
module chan_mux_rr_lane #(
  parameter int WIDTH = 8
) (
  input  logic             grant,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic [WIDTH-1:0] data_m
);
  assign ready  = grant & load & en;
  assign data_m = grant ? data : '0;
endmodule

module chan_mux_rr #(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_ch,
  input  logic                    out_ready
`ifdef CHAN_MUX_RR_CNT_EN
  ,
  input  logic                    clr_cnt,
  output logic [15:0]             xfer_cnt
`endif
);

  // One extra bit so channel arithmetic (ptr + k, NUM_CH itself) never wraps.
  localparam int CW = SEL_W + 1;
  localparam logic [CW-1:0] NCH = CW'(NUM_CH);

  logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0][WIDTH-1:0] ch_data_m;
  logic [NUM_CH-1:0]            grant;
  logic [SEL_W-1:0]             grant_idx;
  logic [SEL_W-1:0]             rr_ptr;
  logic [WIDTH-1:0]             mux_data;
  logic                         load;
  logic                         xfer;

  assign ch_data = in_data;
  assign load    = !out_valid || out_ready;
  // Any ready bit implies its channel is granted; grant implies valid.
  assign xfer    = |in_ready;

  // Arbitration: grant is one-hot or zero.
  always_comb begin
    logic [CW-1:0] cand;
    logic          found;
    grant     = '0;
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    if (!mode) begin
      // Out-of-range select (only possible for non power-of-two NUM_CH)
      // grants nobody.
      if ({1'b0, sel} < NCH) begin
        grant[sel] = in_valid[sel];
        grant_idx  = sel;
      end
    end else begin
      // Search rr_ptr+1, rr_ptr+2, ... wrapping; rr_ptr itself is checked last.
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = {1'b0, rr_ptr} + CW'(k);
        if (cand >= NCH) cand = cand - NCH;
        if (!found && in_valid[cand[SEL_W-1:0]]) begin
          found                   = 1'b1;
          grant[cand[SEL_W-1:0]]  = 1'b1;
          grant_idx               = cand[SEL_W-1:0];
        end
      end
    end
  end

  // Per-channel handshake slices. Ready is held low while in reset so no
  // producer believes a beat was taken that the register then discards.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    chan_mux_rr_lane #(.WIDTH(WIDTH)) u_lane (
      .grant  (grant[i]),
      .load   (load),
      .en     (rst_n),
      .data   (ch_data[i]),
      .ready  (in_ready[i]),
      .data_m (ch_data_m[i])
    );
  end

  // OR-tree mux over masked lane data.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_CH; i++) mux_data = mux_data | ch_data_m[i];
  end

  // Output register and round-robin pointer. rr_ptr resets to the last
  // channel so the first round-robin grant goes to channel 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SEL_W'(NUM_CH - 1);
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_ch    <= grant_idx;
        if (mode) rr_ptr <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CHAN_MUX_RR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      xfer_cnt <= '0;
    else if (clr_cnt)
      xfer_cnt <= '0;
    else if (out_valid && out_ready && (xfer_cnt != 16'hFFFF))
      xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_chan_mux_rr.sv
module tb_chan_mux_rr;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic           mode;
  logic [1:0]     sel;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic [1:0]     out_ch;
  logic           out_ready;
`ifdef CHAN_MUX_RR_CNT_EN
  logic           clr_cnt;
  logic [15:0]    xfer_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  chan_mux_rr #(.NUM_CH(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_ready (out_ready)
`ifdef CHAN_MUX_RR_CNT_EN
    ,
    .clr_cnt   (clr_cnt),
    .xfer_cnt  (xfer_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbiter from the rules: fixed picks sel if valid; round-robin
  // picks the first valid channel after the last granted one.
  function automatic int ref_grant(input logic [N-1:0] v, input logic md,
                                   input int s, input int p);
    if (!md) return (s < N && v[s]) ? s : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (p + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Reset asserted from time zero with traffic on every channel.
    in_valid = 4'hF; in_data = 32'hDDCCBBAA; mode = 1'b1; sel = 2'd0; out_ready = 1'b1;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b exp 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h exp 00", out_data); end
    n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL reset_ch: got %0d exp 0", out_ch); end
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b exp 0000", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    // Load a couple of beats, then reset mid-stream.
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
      n_err++; $display("FAIL midreset_out: got v=%b d=%h ch=%0d exp 0/00/0", out_valid, out_data, out_ch);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    // RR priority back at channel 0.
    n_cmp++; if (in_ready !== 4'b0001) begin n_err++; $display("FAIL midreset_rr: got %b exp 0001", in_ready); end
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF; in_data = 32'h44A52211; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL fixed_ready: got %b exp 0100", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      n_err++; $display("FAIL fixed_out: got v=%b d=%h ch=%0d exp 1/a5/2", out_valid, out_data, out_ch);
    end
    // Unselected channel invalid -> no grant, register empties.
    in_valid = 4'b1011;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL fixed_nogrant: got %b exp 0000", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'hA5) begin
      n_err++; $display("FAIL fixed_bubble: got v=%b d=%h exp 0/a5", out_valid, out_data);
    end
  endtask

  task automatic test_rr_all();
    int exp_seq[5] = '{0, 1, 2, 3, 0};
    do_reset();
    mode = 1'b1; in_valid = 4'hF; in_data = 32'h33221100; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (in_ready !== (4'b0001 << exp_seq[i])) begin
        n_err++; $display("FAIL rr_all_ready[%0d]: got %b exp ch%0d", i, in_ready, exp_seq[i]);
      end
      @(posedge clk); #1;
      n_cmp++; if (out_ch !== 2'(exp_seq[i]) || out_data !== 8'(exp_seq[i] * 8'h11)) begin
        n_err++; $display("FAIL rr_all_out[%0d]: got ch=%0d d=%h exp ch%0d", i, out_ch, out_data, exp_seq[i]);
      end
    end
  endtask

  task automatic test_rr_pair();
    int exp_seq[6] = '{1, 3, 1, 3, 1, 1};
    do_reset();
    mode = 1'b1; in_data = 32'h33221100; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 4) ? 4'b1010 : 4'b0010;
      #1;
      n_cmp++; if (in_ready !== (4'b0001 << exp_seq[i])) begin
        n_err++; $display("FAIL rr_pair_ready[%0d]: got %b exp ch%0d", i, in_ready, exp_seq[i]);
      end
      @(posedge clk); #1;
      n_cmp++; if (out_ch !== 2'(exp_seq[i])) begin
        n_err++; $display("FAIL rr_pair_out[%0d]: got %0d exp %0d", i, out_ch, exp_seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; sel = 2'd1; in_valid = 4'hF; in_data = 32'hDDCC2211; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = 2'($urandom_range(0, 3));
      in_data = $urandom;
      mode = 1'($urandom_range(0, 1));
      #1;
      n_cmp++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b exp 0000", i, in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h22 || out_ch !== 2'd1) begin
        n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d exp 1/22/1", i, out_valid, out_data, out_ch);
      end
    end
    out_ready = 1'b1; mode = 1'b0; sel = 2'd3; in_data = 32'hDD000000;
    #1;
    n_cmp++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL bp_release_ready: got %b exp 1000", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'hDD || out_ch !== 2'd3) begin
      n_err++; $display("FAIL bp_release_out: got v=%b d=%h ch=%0d exp 1/dd/3", out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_random();
    logic         m_vld;
    logic [W-1:0] m_data;
    int           m_ch, m_ptr, g;
    logic         ld;
    logic [N-1:0] exp_rdy;
    do_reset();
    m_vld = 1'b0; m_data = '0; m_ch = 0; m_ptr = N - 1;
    for (int c = 0; c < 500; c++) begin
      in_valid  = 4'($urandom);
      in_data   = $urandom;
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      sel       = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      ld = !m_vld || out_ready;
      g  = ref_grant(in_valid, mode, int'(sel), m_ptr);
      exp_rdy = '0;
      if (ld && g >= 0) exp_rdy[g] = 1'b1;
      n_cmp++; if (in_ready !== exp_rdy) begin
        n_err++; $display("FAIL rand_ready[%0d]: got %b exp %b", c, in_ready, exp_rdy);
      end
      @(posedge clk);
      if (ld) begin
        if (g >= 0) begin
          m_vld = 1'b1; m_data = in_data[g*W +: W]; m_ch = g;
          if (mode) m_ptr = g;
        end else begin
          m_vld = 1'b0;
        end
      end
      #1;
      n_cmp++; if (out_valid !== m_vld || out_data !== m_data || out_ch !== 2'(m_ch)) begin
        n_err++; $display("FAIL rand_out[%0d]: got v=%b d=%h ch=%0d exp %b/%h/%0d",
                          c, out_valid, out_data, out_ch, m_vld, m_data, m_ch);
      end
    end
  endtask

`ifdef CHAN_MUX_RR_CNT_EN
  task automatic test_cnt();
    do_reset();
    clr_cnt = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (xfer_cnt !== 16'd5) begin n_err++; $display("FAIL cnt_five: got %0d exp 5", xfer_cnt); end
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    n_cmp++; if (xfer_cnt !== 16'd0) begin n_err++; $display("FAIL cnt_clr: got %0d exp 0", xfer_cnt); end
    repeat (65540) @(posedge clk);
    #1;
    n_cmp++; if (xfer_cnt !== 16'hFFFF) begin n_err++; $display("FAIL cnt_sat: got %h exp ffff", xfer_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; in_valid = '0; in_data = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
`ifdef CHAN_MUX_RR_CNT_EN
    clr_cnt = 1'b0;
`endif
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_pair();
    test_backpressure();
    test_random();
`ifdef CHAN_MUX_RR_CNT_EN
    test_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
